// File: rtl/ddr2_aref_pkg.sv
// Shared constants for the DDR2 auto-refresh engine: command encodings,
// default geometry and timing, and the FSM state type.
package ddr2_aref_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    localparam int DEF_BA_BITS   = 3;
    localparam int DEF_ADDR_BITS = 14;

    // Device timing in picoseconds at a 5 ns controller clock
    localparam int TCK_PS   = 5000;
    localparam int TREFI_PS = 7_800_000;
    localparam int TRP_PS   = 15_000;
    localparam int TRFC_PS  = 127_500;

    // Round a time up to whole clock cycles so spacing is never violated
    function automatic int ps2cyc(input int ps);
        return (ps + TCK_PS - 1) / TCK_PS;
    endfunction

    localparam int DEF_TREFI_CYC    = ps2cyc(TREFI_PS);
    localparam int DEF_TRP_CYC      = ps2cyc(TRP_PS);
    localparam int DEF_TRFC_CYC     = ps2cyc(TRFC_PS);
    localparam int DEF_MAX_POSTPONE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_PRE,
        ST_WAIT_RP,
        ST_AREF,
        ST_WAIT_RFC
    } aref_state_e;

endpackage

// File: rtl/ddr2_aref_if.sv
// Refresh engine <-> command arbiter bundle. The engine is the master.
interface ddr2_aref_if #(
    parameter int BA_BITS   = 3,
    parameter int ADDR_BITS = 14
);
    logic                 aref_req;
    logic                 aref_en;
    logic [3:0]           aref_cmd;
    logic [BA_BITS-1:0]   aref_ba;
    logic [ADDR_BITS-1:0] aref_addr;
    logic                 aref_end;
    logic                 aref_urgent;
    logic                 aref_overflow;

    modport master (
        input  aref_en,
        output aref_req, aref_cmd, aref_ba, aref_addr,
        output aref_end, aref_urgent, aref_overflow
    );

    modport slave (
        output aref_en,
        input  aref_req, aref_cmd, aref_ba, aref_addr,
        input  aref_end, aref_urgent, aref_overflow
    );
endinterface

// File: rtl/ddr2_aref_timer.sv
// tREFI interval counter plus the outstanding-refresh (debt) counter.
// Each interval wrap adds one refresh owed; each issued AREF pays one back.
module ddr2_aref_timer
    import ddr2_aref_pkg::*;
#(
    parameter int TREFI_CYC    = DEF_TREFI_CYC,
    parameter int MAX_POSTPONE = DEF_MAX_POSTPONE,
    localparam int DEBT_W      = $clog2(MAX_POSTPONE + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic              aref_issue,
    output logic [DEBT_W-1:0] debt,
    output logic              urgent,
    output logic              overflow
);
    localparam int TMR_W = $clog2(TREFI_CYC);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TREFI_CYC - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX = DEBT_W'(MAX_POSTPONE);

    logic [TMR_W-1:0]  timer_r;
    logic [DEBT_W-1:0] debt_r;
    logic [DEBT_W-1:0] debt_nxt_s;
    logic              urgent_r;
    logic              overflow_r;
    logic              tick_s;

    assign tick_s = init_end && (timer_r == TMR_LAST);

    // Next debt: a tick and an AREF in the same cycle cancel out
    always_comb begin
        debt_nxt_s = debt_r;
        if (tick_s && !aref_issue) begin
            if (debt_r != DEBT_MAX) begin
                debt_nxt_s = debt_r + DEBT_W'(1);
            end else begin
                debt_nxt_s = debt_r;
            end
        end else if (aref_issue && !tick_s) begin
            if (debt_r != {DEBT_W{1'b0}}) begin
                debt_nxt_s = debt_r - DEBT_W'(1);
            end else begin
                debt_nxt_s = debt_r;
            end
        end else begin
            debt_nxt_s = debt_r;
        end
    end

    // Interval counter, debt and status flags; all held clear until init completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r    <= {TMR_W{1'b0}};
            debt_r     <= {DEBT_W{1'b0}};
            urgent_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else if (!init_end) begin
            timer_r    <= {TMR_W{1'b0}};
            debt_r     <= {DEBT_W{1'b0}};
            urgent_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            timer_r    <= tick_s ? {TMR_W{1'b0}} : timer_r + TMR_W'(1);
            debt_r     <= debt_nxt_s;
            urgent_r   <= (debt_nxt_s == DEBT_MAX);
            overflow_r <= overflow_r | (tick_s && (debt_r == DEBT_MAX));
        end
    end

    assign debt     = debt_r;
    assign urgent   = urgent_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/ddr2_aref.sv
// Periodic auto-refresh engine. Requests the command bus when refreshes are
// owed, then on grant issues PRE-all, AREF after tRP, and signals completion
// after tRFC. Every bus output comes straight from a register.
module ddr2_aref
    import ddr2_aref_pkg::*;
#(
    parameter int TREFI_CYC    = DEF_TREFI_CYC,
    parameter int TRP_CYC      = DEF_TRP_CYC,
    parameter int TRFC_CYC     = DEF_TRFC_CYC,
    parameter int MAX_POSTPONE = DEF_MAX_POSTPONE,
    parameter int BA_BITS      = DEF_BA_BITS,
    parameter int ADDR_BITS    = DEF_ADDR_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_end,
    ddr2_aref_if.master bus
);
    localparam int DEBT_W   = $clog2(MAX_POSTPONE + 1);
    localparam int WAIT_MAX = (TRFC_CYC > TRP_CYC) ? TRFC_CYC : TRP_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    // Wait states last N-1 cycles; the counter runs down to zero, hence N-2
    localparam logic [WAIT_W-1:0] RP_LOAD  = WAIT_W'((TRP_CYC  > 1) ? TRP_CYC  - 2 : 0);
    localparam logic [WAIT_W-1:0] RFC_LOAD = WAIT_W'((TRFC_CYC > 1) ? TRFC_CYC - 2 : 0);
    // A10 high selects all banks for the precharge
    localparam logic [ADDR_BITS-1:0] A10_MASK = {{(ADDR_BITS-11){1'b0}}, 1'b1, 10'b0};

    aref_state_e          state_r, state_nxt_s;
    logic [WAIT_W-1:0]    wait_r, wait_nxt_s;
    logic                 end_nxt_s;
    logic [3:0]           cmd_nxt_s;
    logic [ADDR_BITS-1:0] addr_nxt_s;
    logic                 req_r, end_r;
    logic [3:0]           cmd_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [DEBT_W-1:0]    debt_s;
    logic                 urgent_s, overflow_s, aref_issue_s;

    // Debt is paid on the same edge the AREF command is registered
    assign aref_issue_s = (state_nxt_s == ST_AREF);

    ddr2_aref_timer #(
        .TREFI_CYC    (TREFI_CYC),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_end   (init_end),
        .aref_issue (aref_issue_s),
        .debt       (debt_s),
        .urgent     (urgent_s),
        .overflow   (overflow_s)
    );

    // Next-state logic; dropping init_end abandons any sequence in flight
    always_comb begin
        state_nxt_s = state_r;
        wait_nxt_s  = wait_r;
        end_nxt_s   = 1'b0;
        if (!init_end) begin
            state_nxt_s = ST_IDLE;
            wait_nxt_s  = {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = (debt_s != {DEBT_W{1'b0}}) ? ST_REQ : ST_IDLE;
                end
                ST_REQ: begin
                    state_nxt_s = bus.aref_en ? ST_PRE : ST_REQ;
                end
                ST_PRE: begin
                    if (TRP_CYC > 1) begin
                        state_nxt_s = ST_WAIT_RP;
                        wait_nxt_s  = RP_LOAD;
                    end else begin
                        state_nxt_s = ST_AREF;
                    end
                end
                ST_WAIT_RP: begin
                    if (wait_r == {WAIT_W{1'b0}}) begin
                        state_nxt_s = ST_AREF;
                    end else begin
                        wait_nxt_s = wait_r - WAIT_W'(1);
                    end
                end
                ST_AREF: begin
                    if (TRFC_CYC > 1) begin
                        state_nxt_s = ST_WAIT_RFC;
                        wait_nxt_s  = RFC_LOAD;
                    end else begin
                        end_nxt_s   = 1'b1;
                        state_nxt_s = (debt_s != {DEBT_W{1'b0}}) ? ST_REQ : ST_IDLE;
                    end
                end
                ST_WAIT_RFC: begin
                    if (wait_r == {WAIT_W{1'b0}}) begin
                        // Bus released; any further refresh needs a fresh grant
                        end_nxt_s   = 1'b1;
                        state_nxt_s = (debt_s != {DEBT_W{1'b0}}) ? ST_REQ : ST_IDLE;
                    end else begin
                        wait_nxt_s = wait_r - WAIT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    wait_nxt_s  = {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Command and address implied by the state being entered
    always_comb begin
        cmd_nxt_s  = CMD_NOP;
        addr_nxt_s = {ADDR_BITS{1'b0}};
        case (state_nxt_s)
            ST_PRE: begin
                cmd_nxt_s  = CMD_PRE;
                addr_nxt_s = A10_MASK;
            end
            ST_AREF: begin
                cmd_nxt_s  = CMD_AREF;
            end
            default: begin
                cmd_nxt_s  = CMD_NOP;
                addr_nxt_s = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // State, wait counter and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wait_r  <= {WAIT_W{1'b0}};
            req_r   <= 1'b0;
            end_r   <= 1'b0;
            cmd_r   <= CMD_NOP;
            addr_r  <= {ADDR_BITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
            req_r   <= (state_nxt_s == ST_REQ);
            end_r   <= end_nxt_s;
            cmd_r   <= cmd_nxt_s;
            addr_r  <= addr_nxt_s;
        end
    end

    assign bus.aref_req      = req_r;
    assign bus.aref_cmd      = cmd_r;
    assign bus.aref_ba       = {BA_BITS{1'b0}};
    assign bus.aref_addr     = addr_r;
    assign bus.aref_end      = end_r;
    assign bus.aref_urgent   = urgent_s;
    assign bus.aref_overflow = overflow_s;

endmodule
